ws_pe_dbuf: RTL and testbench
=============================

Name: ws_pe_dbuf

Overview:
- Next-generation weight-stationary processing element for the systolic array.
- Adds a double-buffered weight: a shadow register loads through a vertical shift chain while the active weight keeps computing. A swap command promotes the shadow weight to active.
- Adds a wider accumulator, runtime signed/unsigned mode, optional saturation with a sticky overflow flag, an optional multiplier pipeline stage, and valid propagation east and south.
- Tiled in a ROWS x COLS grid: activations flow west→east, partial sums and weights flow north→south.

Parameters:
- DATA_WIDTH, 8, width of activations and weights.
- ACC_WIDTH, 32, width of partial sums; must be >= 2*DATA_WIDTH (elaboration error otherwise).
- MUL_PIPE, 0, number of extra multiplier pipeline stages; 0 or 1.
- SATURATE, 1, 1 = clamp accumulation at range limits, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  act_in/psum_in/signed_mode valid this cycle
- act_in  in  DATA_WIDTH  activation from west
- psum_in  in  ACC_WIDTH  partial sum from north
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with valid_in
- w_shift  in  1  shift weight chain this cycle
- w_in  in  DATA_WIDTH  weight from north (shadow chain input)
- w_swap_in  in  1  swap command from north
- clear_flag  in  1  synchronous clear of overflow flag
- valid_out  out  1  registered valid_in to east
- act_out  out  DATA_WIDTH  registered activation to east
- w_out  out  DATA_WIDTH  shadow weight to south (= shadow register)
- w_swap_out  out  1  w_swap_in delayed one cycle, to south
- psum_valid  out  1  psum_out updated this cycle
- psum_out  out  ACC_WIDTH  partial sum to south
- overflow  out  1  sticky saturation/wrap indicator

Behaviour:
- Reset (async, any time, including mid-operation):
  - All outputs go to 0; shadow and active weight registers go to 0.
  - All internal pipeline valids are cleared, so nothing in flight survives.
- Weight chain:
  - On w_shift: shadow <= w_in.
  - w_out is combinationally the shadow register. A column of N PEs therefore loads in N shift cycles, with the bottom row's weight shifted in first.
- Swap:
  - On w_swap_in: active <= shadow (pre-edge value).
  - w_swap_out <= w_swap_in, so the swap ripples down the column one row per cycle, matching the skew of the data wavefront.
- Simultaneous shift and swap in the same cycle: active takes the old shadow value and shadow takes w_in.
- Operand capture:
  - When valid_in is high, the operation uses the active weight value from before the same clock edge.
  - A swap in the same cycle as valid_in does not affect that operand; it affects the next valid.
- East path:
  - valid_out <= valid_in every cycle.
  - act_out <= act_in only when valid_in is high; otherwise it holds its value.
- Arithmetic:
  - Product is 2*DATA_WIDTH bits: signed × signed when signed_mode=1, unsigned × unsigned when 0.
  - The product is sign- or zero-extended to ACC_WIDTH and added to psum_in, computed at ACC_WIDTH+1 bits.
- Overflow detection:
  - Signed mode: the true sum lies outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned mode: a carry out of bit ACC_WIDTH-1.
- On overflow:
  - SATURATE=1: clamp to the nearest limit (signed max/min, or unsigned all-ones).
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - In both cases overflow <= 1 (sticky).
- Overflow flag clearing:
  - clear_flag sets overflow to 0.
  - If clear_flag and a new overflow occur in the same cycle, the new overflow wins and overflow = 1.
- Latency:
  - psum_out and psum_valid appear 1+MUL_PIPE cycles after the valid_in edge.
  - With MUL_PIPE=1, psum_in and signed_mode are internally delayed one stage alongside the registered product, so the caller aligns psum_in with act_in exactly as for MUL_PIPE=0.
  - Throughput is one operation per cycle; there is no stall or backpressure.
- Idle output behaviour: psum_valid is a single-cycle pulse per accepted operation, and psum_out holds its last value when psum_valid is low.

Decomposition:
- Package systolic_pkg holds:
  - localparam defaults (DATA_WIDTH, ACC_WIDTH);
  - function sat_add(a, b, signed_mode, saturate), returning the sum and an overflow bit;
  - typedef for the pipeline stage struct {valid, product, psum, signed_mode}.
- Sub-module ws_mac_stage: multiply/extend/add/saturate datapath with an optional pipeline register, selected by MUL_PIPE.
- The top level owns the weight chain, the swap ripple, the east registers and the flag.

Test Plan:
- Signed MAC: DATA=8, ACC=32, MUL_PIPE=0. Load weight -3 (shift, swap). Apply valid_in with act=5, psum_in=100, signed_mode=1 → one cycle later psum_out=85, psum_valid=1, act_out=5, valid_out=1.
- Unsigned mode with the same bits: weight 0xFD, act=5, psum=100, signed_mode=0 → psum_out=1365.
- Double buffer: active=2, shift shadow=7, then pulse swap and valid_in (act=4, psum=0) in the same cycle → result 8; next valid with act=4 → result 28. w_swap_out pulses one cycle after w_swap_in; w_out=7.
- Saturation: SATURATE=1, psum_in=0x7FFFFFF0, weight=127, act=127, signed → psum_out=0x7FFFFFFF, overflow=1 and stays 1 until clear_flag. With SATURATE=0 the same stimulus → psum_out=0x80003EF1, overflow=1.
- MUL_PIPE=1: a back-to-back stream of 4 valids (act=1,2,3,4; weight=10; psum=0) → psum_valid high for 4 consecutive cycles starting 2 cycles after the first valid, psum_out=10,20,30,40.
- Async reset asserted mid-stream between clock edges → all outputs 0 immediately. No psum_valid appears after deassertion, and active weight=0 (a subsequent valid yields psum_out=psum_in).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic PE family: default widths, the
// MAC pipeline stage record and a width-generic saturating/wrapping adder.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 32;
    // Internal arithmetic width; any ACC_WIDTH below this is supported.
    localparam int ACC_MAX            = 128;

    typedef struct packed {
        logic               valid;
        logic [ACC_MAX-1:0] product;
        logic [ACC_MAX-1:0] psum;
        logic               signed_mode;
    } stage_t;

    typedef struct packed {
        logic [ACC_MAX-1:0] sum;
        logic               ovf;
    } sat_res_t;

    // Operands arrive already sign/zero-extended to ACC_MAX, so the raw sum
    // never wraps and range checks against a width-bit window are exact.
    function automatic sat_res_t sat_add(
        input logic [ACC_MAX-1:0] a,
        input logic [ACC_MAX-1:0] b,
        input int unsigned        width,
        input logic               signed_mode,
        input logic               saturate
    );
        sat_res_t           res;
        logic [ACC_MAX-1:0] s;
        logic [ACC_MAX-1:0] mask;
        logic [ACC_MAX-1:0] smax;
        logic [ACC_MAX-1:0] smin;
        logic               ovf_hi;
        logic               ovf_lo;

        s      = a + b;
        mask   = {ACC_MAX{1'b1}} >> (ACC_MAX - width);
        smax   = mask >> 1;
        smin   = ~smax;
        ovf_hi = signed_mode && ($signed(s) > $signed(smax));
        ovf_lo = signed_mode && ($signed(s) < $signed(smin));

        res.ovf = signed_mode ? (ovf_hi || ovf_lo) : (|(s & ~mask));
        res.sum = s;
        if (res.ovf && saturate) begin
            if (!signed_mode) begin
                res.sum = mask;
            end else if (ovf_hi) begin
                res.sum = smax;
            end else begin
                res.sum = smin;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ws_mac_stage.sv
// Multiply / extend / accumulate / saturate datapath, result registered.
// Latency 1+MUL_PIPE cycles, one op per cycle, no backpressure.
module ws_mac_stage
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int MUL_PIPE   = 0,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] act_i,
    input  logic [DATA_WIDTH-1:0] weight_i,
    input  logic [ACC_WIDTH-1:0]  psum_i,
    input  logic                  signed_mode_i,
    output logic                  psum_valid_o,
    output logic [ACC_WIDTH-1:0]  psum_o,
    output logic                  ovf_hit_o
);
    localparam int PW = 2 * DATA_WIDTH + 2;

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_err_acc
        $error("ws_mac_stage: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end
    if (ACC_WIDTH >= ACC_MAX || PW > ACC_MAX) begin : g_err_max
        $error("ws_mac_stage: widths exceed internal arithmetic width");
    end
    if (MUL_PIPE != 0 && MUL_PIPE != 1) begin : g_err_pipe
        $error("ws_mac_stage: MUL_PIPE must be 0 or 1");
    end

    logic [PW-1:0]        act_x;
    logic [PW-1:0]        wgt_x;
    logic [PW-1:0]        prod_x;
    stage_t               s0;
    stage_t               s1;
    sat_res_t             res;
    logic                 psum_valid_q;
    logic                 psum_valid_d;
    logic [ACC_WIDTH-1:0] psum_q;
    logic [ACC_WIDTH-1:0] psum_d;
    logic                 unused_sum_hi;

    // One multiplier serves both modes: the low PW bits of a product of
    // sign- or zero-extended operands are the exact result either way.
    always_comb begin
        act_x          = {{(PW-DATA_WIDTH){signed_mode_i & act_i[DATA_WIDTH-1]}}, act_i};
        wgt_x          = {{(PW-DATA_WIDTH){signed_mode_i & weight_i[DATA_WIDTH-1]}}, weight_i};
        prod_x         = act_x * wgt_x;
        s0.valid       = valid_i;
        s0.product     = {{(ACC_MAX-PW){prod_x[PW-1]}}, prod_x};
        s0.psum        = {{(ACC_MAX-ACC_WIDTH){signed_mode_i & psum_i[ACC_WIDTH-1]}}, psum_i};
        s0.signed_mode = signed_mode_i;
    end

    if (MUL_PIPE == 1) begin : g_pipe
        stage_t stage_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
            end else begin
                stage_q <= s0;
            end
        end

        assign s1 = stage_q;
    end else begin : g_nopipe
        assign s1 = s0;
    end

    always_comb begin
        res          = sat_add(s1.product, s1.psum, ACC_WIDTH, s1.signed_mode, SATURATE);
        psum_valid_d = s1.valid;
        psum_d       = s1.valid ? res.sum[ACC_WIDTH-1:0] : psum_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
        end else begin
            psum_valid_q <= psum_valid_d;
            psum_q       <= psum_d;
        end
    end

    assign unused_sum_hi = ^res.sum[ACC_MAX-1:ACC_WIDTH];
    assign ovf_hit_o     = s1.valid & res.ovf;
    assign psum_valid_o  = psum_valid_q;
    assign psum_o        = psum_q;

endmodule

// File: rtl/ws_pe_dbuf.sv
// Weight-stationary PE with double-buffered weight, swap ripple and sticky overflow.
// psum latency 1+MUL_PIPE cycles, east/south regs 1 cycle; never stalls.
module ws_pe_dbuf
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int MUL_PIPE   = 0,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  signed_mode,
    input  logic                  w_shift,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_swap_in,
    input  logic                  clear_flag,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] act_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  w_swap_out,
    output logic                  psum_valid,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  overflow
);
    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_err_acc
        $error("ws_pe_dbuf: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shadow_d;
    logic [DATA_WIDTH-1:0] active_q;
    logic [DATA_WIDTH-1:0] active_d;
    logic [DATA_WIDTH-1:0] act_out_q;
    logic [DATA_WIDTH-1:0] act_out_d;
    logic                  valid_out_q;
    logic                  swap_q;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  ovf_hit;

    // Swap reads the pre-edge shadow, so shift+swap in one cycle promotes the
    // old shadow while the new weight lands behind it.
    always_comb begin
        shadow_d   = w_shift   ? w_in     : shadow_q;
        active_d   = w_swap_in ? shadow_q : active_q;
        act_out_d  = valid_in  ? act_in   : act_out_q;
        overflow_d = ovf_hit ? 1'b1 : (clear_flag ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            act_out_q   <= '0;
            valid_out_q <= 1'b0;
            swap_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            act_out_q   <= act_out_d;
            valid_out_q <= valid_in;
            swap_q      <= w_swap_in;
            overflow_q  <= overflow_d;
        end
    end

    // The MAC sees active_q before this edge's swap takes effect.
    ws_mac_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .MUL_PIPE   (MUL_PIPE),
        .SATURATE   (SATURATE)
    ) u_mac (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_in),
        .act_i         (act_in),
        .weight_i      (active_q),
        .psum_i        (psum_in),
        .signed_mode_i (signed_mode),
        .psum_valid_o  (psum_valid),
        .psum_o        (psum_out),
        .ovf_hit_o     (ovf_hit)
    );

    assign valid_out  = valid_out_q;
    assign act_out    = act_out_q;
    assign w_out      = shadow_q;
    assign w_swap_out = swap_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ws_pe_dbuf.sv
// Two PEs (MUL_PIPE=0/SATURATE=1 and MUL_PIPE=1/SATURATE=0) share stimulus;
// a per-edge reference model feeds a scoreboard drained by a negedge monitor.
module tb_ws_pe_dbuf;
    localparam int DW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          valid_in = 1'b0;
    logic [DW-1:0] act_in = '0;
    logic [AW-1:0] psum_in = '0;
    logic          signed_mode = 1'b0;
    logic          w_shift = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_swap_in = 1'b0;
    logic          clear_flag = 1'b0;

    logic [1:0]         vout, swo, pv, ovf;
    logic [1:0][DW-1:0] aout, wout;
    logic [1:0][AW-1:0] po;

    ws_pe_dbuf #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_PIPE(0), .SATURATE(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .act_in(act_in), .psum_in(psum_in),
        .signed_mode(signed_mode), .w_shift(w_shift), .w_in(w_in), .w_swap_in(w_swap_in),
        .clear_flag(clear_flag), .valid_out(vout[0]), .act_out(aout[0]), .w_out(wout[0]),
        .w_swap_out(swo[0]), .psum_valid(pv[0]), .psum_out(po[0]), .overflow(ovf[0]));

    ws_pe_dbuf #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_PIPE(1), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .act_in(act_in), .psum_in(psum_in),
        .signed_mode(signed_mode), .w_shift(w_shift), .w_in(w_in), .w_swap_in(w_swap_in),
        .clear_flag(clear_flag), .valid_out(vout[1]), .act_out(aout[1]), .w_out(wout[1]),
        .w_swap_out(swo[1]), .psum_valid(pv[1]), .psum_out(po[1]), .overflow(ovf[1]));

    typedef struct {
        int          issue;
        logic [31:0] r_sat;
        logic [31:0] r_wrap;
        bit          ovf;
    } exp_t;

    typedef struct {
        bit          vout;
        logic [7:0]  aout;
        logic [7:0]  wout;
        bit          swo;
        bit          clr;
    } edge_t;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    bit          run_chk = 1'b0;
    exp_t        sbq[$];
    int          rd[2] = '{0, 0};
    edge_t       eq[int];
    bit          flag[2] = '{1'b0, 1'b0};
    logic [7:0]  m_shadow = '0;
    logic [7:0]  m_active = '0;
    logic [7:0]  m_aout = '0;
    logic [31:0] last_psum[2];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the rules: exact integer sum, then range test.
    function automatic void ref_mac(input logic [7:0] a, input logic [7:0] w, input logic [31:0] p,
                                    input bit sm, output logic [31:0] r_sat,
                                    output logic [31:0] r_wrap, output bit o);
        longint av, wv, pl, s;
        longint smax, smin, umax;
        smax = 2147483647;
        smin = -smax - 1;
        umax = 64'hFFFF_FFFF;
        if (sm) begin
            av = longint'($signed(a));
            wv = longint'($signed(w));
            pl = longint'($signed(p));
        end else begin
            av = longint'(a);
            wv = longint'(w);
            pl = longint'(p);
        end
        s      = av * wv + pl;
        r_wrap = s[31:0];
        if (sm) o = (s > smax) || (s < smin);
        else    o = (s > umax);
        if (!o)      r_sat = r_wrap;
        else if (!sm) r_sat = 32'hFFFF_FFFF;
        else if (s > 0) r_sat = 32'h7FFF_FFFF;
        else         r_sat = 32'h8000_0000;
    endfunction

    task automatic step(input bit v, input logic [7:0] a, input logic [31:0] p, input bit sm,
                        input bit sh, input logic [7:0] wi, input bit sw, input bit clr);
        int          e;
        exp_t        x;
        edge_t       ed;
        logic [31:0] rs, rw;
        bit          o;
        @(posedge clk);
        #1;
        valid_in = v; act_in = a; psum_in = p; signed_mode = sm;
        w_shift = sh; w_in = wi; w_swap_in = sw; clear_flag = clr;
        e = edge_n + 1;
        if (v) begin
            ref_mac(a, m_active, p, sm, rs, rw, o);
            x.issue = e; x.r_sat = rs; x.r_wrap = rw; x.ovf = o;
            sbq.push_back(x);
            m_aout = a;
        end
        if (sw) m_active = m_shadow;
        if (sh) m_shadow = wi;
        ed.vout = v; ed.aout = m_aout; ed.wout = m_shadow; ed.swo = sw; ed.clr = clr;
        eq[e] = ed;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s valid_out[%0d]", tag, k), vout[k], 0);
            chk($sformatf("%s act_out[%0d]", tag, k), aout[k], 0);
            chk($sformatf("%s w_out[%0d]", tag, k), wout[k], 0);
            chk($sformatf("%s w_swap_out[%0d]", tag, k), swo[k], 0);
            chk($sformatf("%s psum_valid[%0d]", tag, k), pv[k], 0);
            chk($sformatf("%s psum_out[%0d]", tag, k), po[k], 0);
            chk($sformatf("%s overflow[%0d]", tag, k), ovf[k], 0);
        end
    endtask

    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        valid_in = 0; w_shift = 0; w_swap_in = 0; clear_flag = 0;
        m_shadow = '0; m_active = '0; m_aout = '0;
        flag = '{1'b0, 1'b0};
        sbq.delete();
        rd = '{0, 0};
        eq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: instance k presents a result k edges after the edge that sampled it.
    always @(negedge clk) begin : mon
        bit          due;
        bit          ev;
        logic [31:0] er;
        if (run_chk && !reset) begin
            for (int k = 0; k < 2; k++) begin
                due = (rd[k] < sbq.size()) && (sbq[rd[k]].issue + k == edge_n);
                ev  = 1'b0;
                chk($sformatf("psum_valid[%0d]", k), pv[k], due);
                if (due) begin
                    er = (k == 1) ? sbq[rd[k]].r_wrap : sbq[rd[k]].r_sat;
                    chk($sformatf("psum_out[%0d]", k), po[k], er);
                    ev = sbq[rd[k]].ovf;
                    rd[k]++;
                end
                if (pv[k]) last_psum[k] = po[k];
                if (ev) flag[k] = 1'b1;
                else if (eq.exists(edge_n) && eq[edge_n].clr) flag[k] = 1'b0;
                chk($sformatf("overflow[%0d]", k), ovf[k], flag[k]);
                if (eq.exists(edge_n)) begin
                    chk($sformatf("valid_out[%0d]", k), vout[k], eq[edge_n].vout);
                    chk($sformatf("act_out[%0d]", k), aout[k], eq[edge_n].aout);
                    chk($sformatf("w_out[%0d]", k), wout[k], eq[edge_n].wout);
                    chk($sformatf("w_swap_out[%0d]", k), swo[k], eq[edge_n].swo);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] p;
        int          sel;
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_chk = 1'b1;

        // Signed MAC, weight -3
        step(0, 8'h00, 32'd0, 0, 1, 8'hFD, 0, 0);
        step(0, 8'h00, 32'd0, 0, 0, 8'h00, 1, 0);
        step(1, 8'd5, 32'd100, 1, 0, 8'h00, 0, 0);
        idle(3);
        chk("signed_mac0", last_psum[0], 32'd85);
        chk("signed_mac1", last_psum[1], 32'd85);

        // Same bits, unsigned
        step(1, 8'd5, 32'd100, 0, 0, 8'h00, 0, 0);
        idle(3);
        chk("unsigned_mac0", last_psum[0], 32'd1365);
        chk("unsigned_mac1", last_psum[1], 32'd1365);

        // Double buffer: swap lands with a valid but affects only the next one
        step(0, 8'h00, 32'd0, 0, 1, 8'd2, 0, 0);
        step(0, 8'h00, 32'd0, 0, 0, 8'd0, 1, 0);
        step(0, 8'h00, 32'd0, 0, 1, 8'd7, 0, 0);
        step(1, 8'd4, 32'd0, 1, 0, 8'd0, 1, 0);
        step(1, 8'd4, 32'd0, 1, 0, 8'd0, 0, 0);
        idle(3);
        chk("dbuf_second0", last_psum[0], 32'd28);
        chk("dbuf_second1", last_psum[1], 32'd28);

        // Saturation vs wrap, sticky flag, clear, clear colliding with overflow
        step(0, 8'h00, 32'd0, 0, 1, 8'd127, 0, 0);
        step(0, 8'h00, 32'd0, 0, 0, 8'd0, 1, 0);
        step(1, 8'd127, 32'h7FFF_FFF0, 1, 0, 8'd0, 0, 0);
        idle(5);
        chk("sat_psum0", last_psum[0], 32'h7FFF_FFFF);
        chk("wrap_psum1", last_psum[1], 32'h8000_3EF1);
        chk("sticky_ovf0", ovf[0], 1);
        chk("sticky_ovf1", ovf[1], 1);
        step(0, 8'h00, 32'd0, 0, 0, 8'd0, 0, 1);
        idle(2);
        chk("cleared_ovf0", ovf[0], 0);
        step(1, 8'd127, 32'h7FFF_FFF0, 1, 0, 8'd0, 0, 1);
        idle(3);
        chk("clr_vs_new_ovf0", ovf[0], 1);
        step(0, 8'h00, 32'd0, 0, 0, 8'd0, 0, 1);

        // Back-to-back stream, weight 10
        step(0, 8'h00, 32'd0, 0, 1, 8'd10, 0, 0);
        step(0, 8'h00, 32'd0, 0, 0, 8'd0, 1, 0);
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 32'd0, 1, 0, 8'd0, 0, 0);
        idle(3);
        chk("stream_last1", last_psum[1], 32'd40);

        // Async reset between edges with an operation in flight
        step(0, 8'h00, 32'd0, 0, 1, 8'd55, 0, 0);
        step(1, 8'd3, 32'd7, 1, 0, 8'd0, 0, 0);
        mid_reset();
        step(1, 8'd9, 32'd1234, 1, 0, 8'd0, 0, 0);
        idle(3);
        chk("post_reset0", last_psum[0], 32'd1234);
        chk("post_reset1", last_psum[1], 32'd1234);

        // Randomised traffic biased toward the accumulator limits
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       p = $urandom;
                1:       p = 32'h7FFF_C000 + ($urandom & 32'h3FFF);
                2:       p = 32'hFFFF_C000 + ($urandom & 32'h3FFF);
                default: p = 32'h8000_0000 + ($urandom & 32'h3FFF);
            endcase
            step(($urandom_range(0, 9) < 7), 8'($urandom), p, 1'($urandom),
                 ($urandom_range(0, 9) < 3), 8'($urandom), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) == 0));
        end
        idle(4);
        chk("drained0", rd[0], sbq.size());
        chk("drained1", rd[1], sbq.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
